// File: rtl/credit_ledger.sv
// Student credit ledger. Each slot keeps a registered flag, its remaining credit and the
// credit spent in the current hour. It also runs a paced scan that lists low-credit students.
module credit_ledger #(
    parameter int unsigned ID_W      = 3,
    parameter int unsigned CREDIT_W  = 6,
    parameter int unsigned AMT_W     = 3,
    parameter int unsigned SPEND_CAP = 5,
    parameter int unsigned DAY_HOURS = 24,
    parameter int unsigned TIME_W    = 5
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     incTime,
    input  logic                     op_valid,
    input  logic [2:0]               mode,
    input  logic [ID_W-1:0]          studentID,
    input  logic [AMT_W-1:0]         credit,
    input  logic                     listNext,
    output logic                     busy,
    output logic                     ack,
    output logic                     err,
    output logic [TIME_W-1:0]        stime,
    output logic [ID_W-1:0]          idOutput,
    output logic                     idValid,
    output logic                     endOfListWar,
    output logic [ID_W:0]            studentCount,
    output logic [CREDIT_W+ID_W-1:0] totalCredits
);

    localparam int unsigned NSLOT   = 1 << ID_W;
    localparam int unsigned SPENT_W = $clog2(SPEND_CAP + 1);
    localparam int unsigned SUM_W   = CREDIT_W + 1;

    localparam logic [ID_W-1:0]   LAST_ID    = ID_W'(NSLOT - 1);
    localparam logic [TIME_W-1:0] LAST_HOUR  = TIME_W'(DAY_HOURS - 1);
    localparam logic [SUM_W-1:0]  CREDIT_MAX = SUM_W'((1 << CREDIT_W) - 1);
    localparam logic [SUM_W-1:0]  CAP_WIDE   = SUM_W'(SPEND_CAP);
    localparam logic [SPENT_W-1:0] CAP_SPENT = SPENT_W'(SPEND_CAP);

    localparam logic [2:0] ModeReg    = 3'd0;
    localparam logic [2:0] ModeSpend  = 3'd1;
    localparam logic [2:0] ModeLoad   = 3'd2;
    localparam logic [2:0] ModeList   = 3'd3;
    localparam logic [2:0] ModeRemove = 3'd4;

    typedef enum logic [1:0] {StIdle, StScan, StHold, StDone} state_t;

    state_t                     state_q, state_d;
    logic [NSLOT-1:0]           reg_q, reg_d;
    logic [CREDIT_W-1:0]        cred_q [NSLOT];
    logic [CREDIT_W-1:0]        cred_d [NSLOT];
    logic [SPENT_W-1:0]         spent_q [NSLOT];
    logic [SPENT_W-1:0]         spent_d [NSLOT];
    logic [ID_W-1:0]            idx_q, idx_d;
    logic [AMT_W-1:0]           thr_q, thr_d;
    logic [TIME_W-1:0]          stime_q, stime_d;
    logic                       busy_q, busy_d;
    logic                       ack_q, ack_d;
    logic                       err_q, err_d;
    logic [ID_W-1:0]            id_out_q, id_out_d;
    logic                       id_valid_q, id_valid_d;
    logic                       eol_q, eol_d;
    logic [ID_W:0]              count_q, count_d;
    logic [CREDIT_W+ID_W-1:0]   total_q, total_d;

    logic [SUM_W-1:0]           load_sum;
    logic                       accept;

    // Next-state for the hour counter, the scan FSM and all op effects on the slot table.
    always_comb begin
        state_d    = state_q;
        reg_d      = reg_q;
        cred_d     = cred_q;
        spent_d    = spent_q;
        idx_d      = idx_q;
        thr_d      = thr_q;
        stime_d    = stime_q;
        busy_d     = busy_q;
        id_out_d   = id_out_q;
        id_valid_d = id_valid_q;
        eol_d      = eol_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        load_sum   = '0;
        accept     = 1'b0;

        if (incTime) begin
            stime_d = (stime_q == LAST_HOUR) ? '0 : stime_q + TIME_W'(1);
            for (int i = 0; i < NSLOT; i++) begin
                spent_d[i] = '0;
            end
        end

        // Scan progresses independently of ops; ops are rejected while busy anyway.
        unique case (state_q)
            StScan: begin
                if (reg_q[idx_q] && (cred_q[idx_q] < CREDIT_W'(thr_q))) begin
                    id_out_d   = idx_q;
                    id_valid_d = 1'b1;
                    state_d    = StHold;
                end else if (idx_q == LAST_ID) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + ID_W'(1);
                end
            end
            StHold: begin
                if (listNext) begin
                    id_valid_d = 1'b0;
                    id_out_d   = '0;
                    if (idx_q == LAST_ID) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + ID_W'(1);
                        state_d = StScan;
                    end
                end
            end
            StDone: begin
                eol_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: ;
        endcase

        // An hour tick swallows a coincident op without ack or err.
        if (op_valid && !incTime) begin
            if (busy_q) begin
                err_d = 1'b1;
            end else begin
                case (mode)
                    ModeReg: begin
                        if (studentID != '0 && !reg_q[studentID]) begin
                            reg_d[studentID]   = 1'b1;
                            cred_d[studentID]  = '0;
                            spent_d[studentID] = '0;
                            accept             = 1'b1;
                        end
                    end
                    ModeSpend: begin
                        if (reg_q[studentID] && (cred_q[studentID] >= CREDIT_W'(credit)) &&
                            (SUM_W'(spent_q[studentID]) + SUM_W'(credit) <= CAP_WIDE)) begin
                            cred_d[studentID]  = cred_q[studentID] - CREDIT_W'(credit);
                            spent_d[studentID] = spent_q[studentID] + SPENT_W'(credit);
                            accept             = 1'b1;
                        end
                    end
                    ModeLoad: begin
                        for (int i = 0; i < NSLOT; i++) begin
                            if (reg_q[i] && (spent_q[i] < CAP_SPENT)) begin
                                load_sum  = SUM_W'(cred_q[i]) + SUM_W'(credit);
                                cred_d[i] = (load_sum > CREDIT_MAX) ? '1 :
                                            load_sum[CREDIT_W-1:0];
                            end
                        end
                        accept = 1'b1;
                    end
                    ModeList: begin
                        thr_d   = credit;
                        idx_d   = ID_W'(1);
                        busy_d  = 1'b1;
                        state_d = StScan;
                        accept  = 1'b1;
                    end
                    ModeRemove: begin
                        if (reg_q[studentID]) begin
                            reg_d[studentID]   = 1'b0;
                            cred_d[studentID]  = '0;
                            spent_d[studentID] = '0;
                            accept             = 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (accept) begin
                    ack_d      = 1'b1;
                    eol_d      = 1'b0;
                    id_valid_d = 1'b0;
                    id_out_d   = '0;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    // Count and credit total follow directly from the next slot table; unregistered slots hold 0.
    always_comb begin
        count_d = '0;
        total_d = '0;
        for (int i = 0; i < NSLOT; i++) begin
            count_d = count_d + (ID_W + 1)'(reg_d[i]);
            total_d = total_d + (CREDIT_W + ID_W)'(cred_d[i]);
        end
    end

    // All state and registered outputs, including the scan FSM state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            reg_q      <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                cred_q[i]  <= '0;
                spent_q[i] <= '0;
            end
            idx_q      <= '0;
            thr_q      <= '0;
            stime_q    <= '0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            id_out_q   <= '0;
            id_valid_q <= 1'b0;
            eol_q      <= 1'b0;
            count_q    <= '0;
            total_q    <= '0;
        end else begin
            state_q    <= state_d;
            reg_q      <= reg_d;
            for (int i = 0; i < NSLOT; i++) begin
                cred_q[i]  <= cred_d[i];
                spent_q[i] <= spent_d[i];
            end
            idx_q      <= idx_d;
            thr_q      <= thr_d;
            stime_q    <= stime_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            id_out_q   <= id_out_d;
            id_valid_q <= id_valid_d;
            eol_q      <= eol_d;
            count_q    <= count_d;
            total_q    <= total_d;
        end
    end

    assign busy         = busy_q;
    assign ack          = ack_q;
    assign err          = err_q;
    assign stime        = stime_q;
    assign idOutput     = id_out_q;
    assign idValid      = id_valid_q;
    assign endOfListWar = eol_q;
    assign studentCount = count_q;
    assign totalCredits = total_q;

endmodule

// File: doc/credit_ledger.md
Name: credit_ledger

Overview:
- Parametrised student credit ledger: register/remove students, spend credit, broadcast hourly loads, and list low-credit students.
- Per-slot state: registered flag, remaining credit, credit spent this hour.
- Adds over the previous generation: reset, remove op, ack/err handshake, per-hour spend cap, saturating loads, and a paced warning-list scan FSM.
- Sits between the front-panel op decoder and the display driver.

Parameters:
ID_W, 3, ID width; valid IDs 1..2^ID_W-1; ID 0 is never a student
CREDIT_W, 6, remaining-credit width per student
AMT_W, 3, width of the credit/amount operand
SPEND_CAP, 5, max credit spendable per student per hour; also the load gate
DAY_HOURS, 24, stime wraps to 0 on reaching this value
TIME_W, 5, stime width; must satisfy 2^TIME_W >= DAY_HOURS

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
incTime  in  1  advance hour (single-cycle pulse)
op_valid  in  1  op request strobe
mode  in  3  0 register, 1 spend, 2 load-all, 3 list, 4 remove
studentID  in  ID_W  target student
credit  in  AMT_W  amount (modes 1, 2) or threshold (mode 3)
listNext  in  1  consumer has taken idOutput; advance scan
busy  out  1  list scan active
ack  out  1  one-cycle pulse: op accepted
err  out  1  one-cycle pulse: op rejected
stime  out  TIME_W  current hour
idOutput  out  ID_W  listed student, 0 when idValid=0
idValid  out  1  idOutput holds a listed student
endOfListWar  out  1  scan finished; held until next accepted op
studentCount  out  ID_W+1  registered students
totalCredits  out  CREDIT_W+ID_W  sum of all remaining credit

Behaviour:
- RST (async): all slots cleared; all outputs 0; FSM to IDLE.
- Registered outputs. Op effects and ack/err appear on the edge that samples op_valid (visible next cycle).
- incTime:
  - stime+1; if the result equals DAY_HOURS, stime=0.
  - All spent-this-hour counters cleared.
  - Takes priority: an op_valid in the same cycle is dropped, with no ack or err.
  - Honoured in every FSM state.
- mode 0 register:
  - ID 0 or already registered -> err.
  - Otherwise slot set registered with credit 0 and spent 0; studentCount+1; ack.
- mode 4 remove:
  - Not registered -> err.
  - Otherwise totalCredits -= slot credit; slot cleared; studentCount-1; ack.
- mode 1 spend:
  - Accept iff registered AND credit_rem >= credit AND spent+credit <= SPEND_CAP.
  - On accept: credit_rem -= credit, spent += credit, totalCredits -= credit, ack.
  - Otherwise err, no state change. credit=0 is accepted with no change.
- mode 2 load-all:
  - Every registered slot with spent < SPEND_CAP gets credit_rem += credit, saturating at 2^CREDIT_W-1.
  - totalCredits increases by the sum of amounts actually added.
  - Always ack.
- Any accepted op clears endOfListWar, idValid and idOutput.
- mode 3 list FSM (IDLE -> SCAN -> HOLD -> ... -> DONE -> IDLE):
  - IDLE, mode 3: latch threshold=credit, idx=1, busy=1, ack.
  - SCAN: examine one slot per cycle.
    - Match (registered AND credit_rem < threshold): idOutput=idx, idValid=1, go to HOLD.
    - No match: idx+1.
    - After slot 2^ID_W-1: go to DONE.
  - HOLD: hold outputs until listNext; then idValid=0, idOutput=0, idx+1, return to SCAN (or DONE if past the last slot).
  - DONE: endOfListWar=1, busy=0, return to IDLE.
  - Slot values are read live during the scan. op_valid while busy=1 -> err, no effect. listNext outside HOLD is ignored.
- Arithmetic:
  - Operands are zero-extended to the destination width.
  - Spend never underflows because of the acceptance check.
  - totalCredits never overflows, since its width covers every slot at saturation.

Test Plan:
- RST mid-scan (busy=1, idValid=1) -> next cycle all outputs 0; mode 1 on ID 3 -> err.
- Register 3, register 3 again, register 0 -> ack, err, err; studentCount=1.
- Register 2; load 7 ten times -> credit 63 (saturated), totalCredits=63.
- Spend 3, then spend 3 on ID 2 -> first ack, second err (SPEND_CAP); incTime; spend 3 -> ack; credit=57.
- Register 1, 5; load 2 with ID 1 spent=5 -> ID 1 unchanged, ID 5 gains 2.
- 23 incTime pulses, then 1 more with op_valid asserted -> stime 23 then 0; op dropped, no ack or err.
- IDs 2, 4, 6 with credits 1, 7, 0; list threshold 3 -> idOutput 2, hold with no listNext for 5 cycles, listNext -> 6, listNext -> endOfListWar=1.
